// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver: one MSB-first frame per chip-select window, presented on a
// one-deep valid/ready buffer. Define SPI_RX_PARITY_EN to expect a trailing even-parity bit.
module ptmch_spi_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK200M,
  input  logic                  RESET,
  input  logic                  SPI_CS,
  input  logic                  SPI_CLK,
  input  logic                  SPI_MOSI,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  RX_VALID,
  input  logic                  RX_READY,
  output logic                  RX_ERR,
  output logic                  RX_OVF,
  output logic                  BUSY
);
`ifdef SPI_RX_PARITY_EN
  localparam int NBITS = FRAME_BITS + 1;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam int CW = $clog2(NBITS + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, mosi_sync;
  logic                   cs_d, clk_d, mosi_d;
  logic                   cs_fall, cs_rise, clk_rise;
  logic [NBITS-1:0]       sh;
  logic [CW-1:0]          cnt;
  logic                   frame_ok, load, ovf, err;
  logic [FRAME_BITS-1:0]  frame_data;

  // Edge pulses are registered; mosi_d is delayed by the same flop so it lines up with clk_rise.
  always_ff @(posedge CLK200M or posedge RESET) begin
    if (RESET) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      clk_d     <= 1'b0;
      mosi_d    <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      clk_rise  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      clk_d     <= clk_sync[SYNC_STAGES-1];
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
      cs_fall   <= cs_d & ~cs_sync[SYNC_STAGES-1];
      cs_rise   <= ~cs_d & cs_sync[SYNC_STAGES-1];
      clk_rise  <= ~clk_d & clk_sync[SYNC_STAGES-1];
    end
  end

`ifdef SPI_RX_PARITY_EN
  assign frame_ok   = (cnt == CW'(NBITS)) && !(^sh);
  assign frame_data = sh[NBITS-1:1];
`else
  assign frame_ok   = (cnt == CW'(NBITS));
  assign frame_data = sh;
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    ovf     = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE:  if (cs_fall) state_n = SHIFT;
      SHIFT: if (cs_rise) state_n = CHECK;
      CHECK: begin
        state_n = cs_fall ? SHIFT : IDLE;
        if (!frame_ok)                err  = 1'b1;
        else if (RX_VALID && !RX_READY) ovf = 1'b1;
        else                          load = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK200M or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      RX_OVF   <= 1'b0;
    end else begin
      state  <= state_n;
      RX_ERR <= err;
      RX_OVF <= ovf;
      if ((state == IDLE || state == CHECK) && cs_fall) begin
        cnt <= '0;
      end else if (state == SHIFT && clk_rise) begin
        sh <= {sh[NBITS-2:0], mosi_d};
        // Saturate one past the target so over-long frames stay distinguishable.
        if (cnt != CW'(NBITS + 1)) cnt <= cnt + CW'(1);
      end
      if (load) begin
        RX_DATA  <= frame_data;
        RX_VALID <= 1'b1;
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_ptmch_spi_rx.sv
// Directed bench for ptmch_spi_rx: bit-banged SPI frames, negedge monitor, hand-computed expectations.
`timescale 1ns/1ps
module tb_ptmch_spi_rx;
  localparam int FB = 16;
  localparam int SS = 2;

  logic          CLK200M = 1'b0;
  logic          RESET = 1'b1;
  logic          SPI_CS = 1'b1;
  logic          SPI_CLK = 1'b0;
  logic          SPI_MOSI = 1'b0;
  logic          RX_READY = 1'b0;
  logic [FB-1:0] RX_DATA;
  logic          RX_VALID, RX_ERR, RX_OVF, BUSY;

  ptmch_spi_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .CLK200M(CLK200M), .RESET(RESET), .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK),
    .SPI_MOSI(SPI_MOSI), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .RX_ERR(RX_ERR), .RX_OVF(RX_OVF), .BUSY(BUSY)
  );

  always #2.5 CLK200M = ~CLK200M;

  int nchk = 0, nerr = 0;
  int cyc = 0, cs_hi_cyc = 0;
  int n_err = 0, n_ovf = 0, v_hi = 0, busy_fall = 0, hold_bad = 0, vrise_cyc = 0;
  logic [FB-1:0] words[$];
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_busy = 1'b0;
  logic [FB-1:0] prev_d = '0;

  always @(posedge CLK200M) cyc <= cyc + 1;

  // Inputs change 1ns after posedge, so negedge values are what the next posedge sees.
  always @(negedge CLK200M) begin
    if (RESET) begin
      prev_v    <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (RX_VALID && RX_READY) words.push_back(RX_DATA);
      if (RX_ERR) n_err <= n_err + 1;
      if (RX_OVF) n_ovf <= n_ovf + 1;
      if (RX_VALID) v_hi <= v_hi + 1;
      if (RX_VALID && !prev_v) vrise_cyc <= cyc;
      if (prev_busy && !BUSY) busy_fall <= busy_fall + 1;
      if (prev_v && RX_VALID && !prev_r && RX_DATA != prev_d) hold_bad <= hold_bad + 1;
      prev_v    <= RX_VALID;
      prev_r    <= RX_READY;
      prev_d    <= RX_DATA;
      prev_busy <= BUSY;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK200M);
    #1;
  endtask

  task automatic spi_frame(input logic [31:0] val, input int nb, input int half);
    SPI_CS = 1'b0;
    tick(half);
    for (int i = nb - 1; i >= 0; i--) begin
      SPI_MOSI = val[i];
      tick(half);
      SPI_CLK = 1'b1;
      tick(half);
      SPI_CLK = 1'b0;
    end
    tick(half);
    SPI_CS = 1'b1;
    cs_hi_cyc = cyc;
  endtask

  task automatic send(input logic [31:0] w, input int nb, input int half);
`ifdef SPI_RX_PARITY_EN
    spi_frame({w[30:0], ^w}, nb + 1, half);
`else
    spi_frame(w, nb, half);
`endif
  endtask

  int w0, e0, o0, vh0, bf0;

  initial begin
    RX_READY = 1'b1;
    tick(3);
    chk("rst_data", RX_DATA, 0);
    chk("rst_valid", RX_VALID, 0);
    chk("rst_err", RX_ERR, 0);
    chk("rst_ovf", RX_OVF, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;
    tick(3);

    // 1: single frame, latency and single-cycle valid
    w0 = words.size(); e0 = n_err; o0 = n_ovf; vh0 = v_hi;
    send(32'hA5C3, 16, 6);
    tick(20);
    chk("t1_count", words.size() - w0, 1);
    chk("t1_data", words[w0], 32'hA5C3);
    chk("t1_latency", vrise_cyc - (cs_hi_cyc + 1), SS + 2);
    chk("t1_vhi", v_hi - vh0, 1);
    chk("t1_err", n_err - e0, 0);
    chk("t1_ovf", n_ovf - o0, 0);

    // 2: held word, overrun on second frame, then release
    RX_READY = 1'b0;
    w0 = words.size(); e0 = n_err; o0 = n_ovf;
    send(32'h1234, 16, 6);
    tick(20);
    chk("t2_valid_held", RX_VALID, 1);
    chk("t2_data_held", RX_DATA, 32'h1234);
    send(32'h5678, 16, 6);
    tick(20);
    chk("t2_ovf", n_ovf - o0, 1);
    chk("t2_data_kept", RX_DATA, 32'h1234);
    chk("t2_valid_kept", RX_VALID, 1);
    RX_READY = 1'b1;
    tick(1);
    chk("t2_valid_fall", RX_VALID, 0);
    tick(20);
    chk("t2_count", words.size() - w0, 1);
    chk("t2_word", words[w0], 32'h1234);
    chk("t2_err", n_err - e0, 0);
    chk("t2_hold", hold_bad, 0);

    // 3: short and long frames, then a good one
    w0 = words.size(); e0 = n_err;
    send(32'h7FFF, 15, 5);
    tick(20);
    send(32'h1FFFF, 17, 5);
    tick(20);
    chk("t3_err", n_err - e0, 2);
    chk("t3_valid", RX_VALID, 0);
    chk("t3_nodeliver", words.size() - w0, 0);
    send(32'hFFFF, 16, 5);
    tick(20);
    chk("t3_count", words.size() - w0, 1);
    chk("t3_word", words[w0], 32'hFFFF);

    // 4: reset mid-frame
    w0 = words.size(); e0 = n_err;
    SPI_CS = 1'b0;
    tick(5);
    for (int i = 0; i < 8; i++) begin
      SPI_MOSI = i[0];
      tick(5);
      SPI_CLK = 1'b1;
      tick(5);
      SPI_CLK = 1'b0;
    end
    RESET = 1'b1;
    tick(1);
    chk("t4_rst_busy", BUSY, 0);
    chk("t4_rst_valid", RX_VALID, 0);
    SPI_CS = 1'b1;
    SPI_MOSI = 1'b0;
    tick(3);
    RESET = 1'b0;
    tick(5);
    send(32'h00FF, 16, 5);
    tick(20);
    chk("t4_count", words.size() - w0, 1);
    chk("t4_word", words[w0], 32'h00FF);
    chk("t4_err", n_err - e0, 0);

    // 5: 25 MHz back-to-back frames, CS high 4 cycles between
    w0 = words.size(); e0 = n_err; bf0 = busy_fall;
    send(32'h0001, 16, 4);
    tick(4);
    send(32'h8000, 16, 4);
    tick(20);
    chk("t5_count", words.size() - w0, 2);
    chk("t5_first", words[w0], 32'h0001);
    chk("t5_second", words[w0 + 1], 32'h8000);
    chk("t5_busy_gap", busy_fall - bf0, 2);
    chk("t5_err", n_err - e0, 0);

`ifdef SPI_RX_PARITY_EN
    // 6: parity good then bad
    w0 = words.size(); e0 = n_err;
    spi_frame({16'h0003, 1'b0}, 17, 5);
    tick(20);
    chk("t6_count", words.size() - w0, 1);
    chk("t6_word", words[w0], 32'h0003);
    spi_frame({16'h0003, 1'b1}, 17, 5);
    tick(20);
    chk("t6_err", n_err - e0, 1);
    chk("t6_nodeliver", words.size() - w0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
